address_sequencer: RTL and testbench

Parametrised address sequencer driving BRAM/DMA read or write ports in the acquisition and playback paths. Generates a byte address stream `base + n*stride*2^BYTE_SHIFT` for `n = 0..count_max`, with a ready/valid handshake for backpressure. Supports continuous (wrapping) and single-shot modes, with start/done control. Configuration is re-latched at every pass boundary.

---
 rtl/address_sequencer_pkg.sv | 12 +
 rtl/address_sequencer.sv | 120 ++++++++++++
 tb/tb_address_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/address_sequencer_pkg.sv
// Shared state encoding and mode constants for the address sequencer.
package address_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/address_sequencer.sv
// Byte address stream generator (base + n*stride << BYTE_SHIFT) with ready/valid
// backpressure, continuous or single-shot passes and pass-boundary config re-latch.
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 13,
  parameter int STRIDE_WIDTH = 8,
  parameter int BYTE_SHIFT   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    sclr,
  input  logic                    start,
  input  logic                    mode,
  input  logic [COUNT_WIDTH-1:0]  count_max,
  input  logic [ADDR_WIDTH-1:0]   base,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic                    ready,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    valid,
  output logic                    last,
  output logic                    busy,
  output logic                    done
);

  state_t                  r_state,     w_state_nxt;
  logic                    r_mode,      w_mode_nxt;
  logic [COUNT_WIDTH-1:0]  r_count,     w_count_nxt;
  logic [COUNT_WIDTH-1:0]  r_count_max, w_count_max_nxt;
  logic [STRIDE_WIDTH-1:0] r_stride,    w_stride_nxt;
  logic [ADDR_WIDTH-1:0]   r_address,   w_address_nxt;
  logic                    r_done,      w_done_nxt;
  logic                    w_run;
  logic                    w_last;

  // Stride is zero-extended before the shift so the step never sign-extends.
  function automatic logic [ADDR_WIDTH-1:0] f_step(input logic [STRIDE_WIDTH-1:0] s);
    return {{(ADDR_WIDTH-STRIDE_WIDTH){1'b0}}, s} << BYTE_SHIFT;
  endfunction

  assign w_run  = (r_state == ST_RUN);
  // Gated by RUN so the reset-time match of count==count_max_reg==0 stays hidden.
  assign w_last = w_run && (r_count == r_count_max);

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_count_nxt     = r_count;
    w_count_max_nxt = r_count_max;
    w_stride_nxt    = r_stride;
    w_address_nxt   = r_address;
    w_done_nxt      = 1'b0;

    if (sclr) begin
      w_state_nxt   = ST_IDLE;
      w_count_nxt   = '0;
      w_address_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt     = ST_RUN;
            w_mode_nxt      = mode;
            w_count_max_nxt = count_max;
            w_stride_nxt    = stride;
            w_count_nxt     = '0;
            w_address_nxt   = base;
          end
        end
        ST_RUN: begin
          if (ready) begin
            if (!w_last) begin
              w_count_nxt   = r_count + COUNT_WIDTH'(1);
              w_address_nxt = r_address + f_step(r_stride);
            end else if (r_mode == MODE_SINGLE) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              // Wrap: fresh config takes effect with no bubble.
              w_mode_nxt      = mode;
              w_count_max_nxt = count_max;
              w_stride_nxt    = stride;
              w_count_nxt     = '0;
              w_address_nxt   = base;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_count     <= '0;
      r_count_max <= '0;
      r_stride    <= '0;
      r_address   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_count     <= w_count_nxt;
      r_count_max <= w_count_max_nxt;
      r_stride    <= w_stride_nxt;
      r_address   <= w_address_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign address = r_address;
  assign valid   = w_run;
  assign busy    = w_run;
  assign last    = w_last;
  assign done    = r_done;

endmodule

// File: tb/tb_address_sequencer.sv
// Scoreboard bench for address_sequencer: directed passes push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_address_sequencer;
  import address_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, sclr, start, mode, ready;
  logic [12:0] count_max;
  logic [31:0] base;
  logic [7:0]  stride;
  logic [31:0] address;
  logic        valid, last, busy, done;

  typedef struct {
    logic [31:0] a;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  logic  done_prev = 1'b0;

  address_sequencer #(
    .ADDR_WIDTH(32), .COUNT_WIDTH(13), .STRIDE_WIDTH(8), .BYTE_SHIFT(2)
  ) dut (
    .clk(clk), .resetn(resetn), .sclr(sclr), .start(start), .mode(mode),
    .count_max(count_max), .base(base), .stride(stride), .ready(ready),
    .address(address), .valid(valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic l);
    beat_t b;
    b.a = a;
    b.l = l;
    q.push_back(b);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    ready = 1'b0;
    sclr  = 1'b1;
    cyc(1);
    sclr  = 1'b0;
  endtask

  task automatic cfg(input logic m, input logic [31:0] b, input logic [7:0] s,
                     input logic [12:0] cm);
    mode = m; base = b; stride = s; count_max = cm;
  endtask

  // Monitor: a beat is taken when valid && ready at the coming edge (sclr overrides).
  always @(negedge clk) begin
    beat_t e;
    if (resetn && valid && ready && !sclr) begin
      if (q.size() == 0) begin
        check("unexpected_beat", address, 32'hDEAD_BEEF);
      end else begin
        e = q.pop_front();
        check("beat_addr", address, e.a);
        check("beat_last", {31'd0, last}, {31'd0, e.l});
      end
    end
    if (done) begin
      done_cnt++;
      check("done_single_cycle", {31'd0, done_prev}, 32'd0);
      check("done_valid_overlap", {31'd0, valid}, 32'd0);
    end
    done_prev = done;
  end

  initial begin
    int d0;
    resetn = 1'b1; sclr = 1'b0; start = 1'b0; ready = 1'b0;
    cfg(MODE_CONT, 32'h0, 8'h0, 13'd0);
    #2 resetn = 1'b0;
    #1;
    check("rst_address", address, 32'h0);
    check("rst_flags", {28'd0, valid, last, busy, done}, 32'h0);
    cyc(2);
    resetn = 1'b1;
    cyc(1);

    // Continuous wrap with no bubble.
    cfg(MODE_CONT, 32'h0, 8'd1, 13'd3);
    ready = 1'b1;
    push(32'd0, 0); push(32'd4, 0); push(32'd8, 0); push(32'd12, 1);
    push(32'd0, 0); push(32'd4, 0); push(32'd8, 0); push(32'd12, 1);
    do_start();
    check("start_latency_valid", {31'd0, valid}, 32'd1);
    cyc(8);
    check("cont_queue_empty", q.size(), 32'd0);
    do_clear();
    check("cont_clear_valid", {31'd0, valid}, 32'd0);

    // Single-shot pass then done pulse.
    cfg(MODE_SINGLE, 32'h1000, 8'd3, 13'd2);
    ready = 1'b1;
    push(32'h1000, 0); push(32'h100C, 0); push(32'h1018, 1);
    d0 = done_cnt;
    do_start();
    cyc(3);
    check("single_valid_after", {31'd0, valid}, 32'd0);
    check("single_done_hi", {31'd0, done}, 32'd1);
    cyc(1);
    check("single_done_lo", {31'd0, done}, 32'd0);
    check("single_done_count", done_cnt - d0, 32'd1);
    check("single_queue_empty", q.size(), 32'd0);

    // Backpressure: ready 1,0,0,1.
    cfg(MODE_SINGLE, 32'h200, 8'd2, 13'd3);
    ready = 1'b1;
    push(32'h200, 0); push(32'h208, 0); push(32'h210, 0); push(32'h218, 1);
    do_start();
    cyc(1);
    ready = 1'b0;
    cyc(1);
    check("bp_hold1", address, 32'h208);
    cyc(1);
    check("bp_hold2", address, 32'h208);
    ready = 1'b1;
    cyc(3);
    check("bp_done", {31'd0, done}, 32'd1);
    check("bp_queue_empty", q.size(), 32'd0);
    cyc(1);

    // Re-latch: count_max changed mid-pass only affects the next pass.
    cfg(MODE_CONT, 32'h40, 8'd1, 13'd3);
    ready = 1'b1;
    push(32'h40, 0); push(32'h44, 0); push(32'h48, 0); push(32'h4C, 1);
    push(32'h40, 0); push(32'h44, 1); push(32'h40, 0); push(32'h44, 1);
    do_start();
    count_max = 13'd1;
    cyc(8);
    check("relatch_queue_empty", q.size(), 32'd0);
    do_clear();

    // sclr at beat 2 together with ready and start.
    cfg(MODE_SINGLE, 32'h300, 8'd1, 13'd5);
    ready = 1'b1;
    push(32'h300, 0); push(32'h304, 0);
    d0 = done_cnt;
    do_start();
    cyc(2);
    sclr = 1'b1; start = 1'b1;
    cyc(1);
    check("sclr_address", address, 32'h0);
    check("sclr_flags", {28'd0, valid, last, busy, done}, 32'h0);
    sclr = 1'b0; start = 1'b0;
    cyc(2);
    check("sclr_no_done", done_cnt - d0, 32'd0);
    check("sclr_start_ignored", {31'd0, valid}, 32'd0);
    check("sclr_queue_empty", q.size(), 32'd0);

    // Asynchronous reset mid-pass.
    cfg(MODE_CONT, 32'h500, 8'd1, 13'd7);
    ready = 1'b1;
    push(32'h500, 0); push(32'h504, 0);
    do_start();
    cyc(2);
    ready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("areset_address", address, 32'h0);
    check("areset_flags", {28'd0, valid, last, busy, done}, 32'h0);
    cyc(1);
    resetn = 1'b1;
    cyc(1);

    // count_max=0: every beat last, base re-latched each beat.
    cfg(MODE_CONT, 32'h20, 8'd5, 13'd0);
    ready = 1'b1;
    push(32'h20, 1); push(32'h30, 1); push(32'h40, 1);
    do_start();
    base = 32'h30;
    cyc(1);
    base = 32'h40;
    cyc(2);
    check("cm0_queue_empty", q.size(), 32'd0);
    do_clear();

    // Address wrap modulo 2^32, then start in the done cycle.
    cfg(MODE_SINGLE, 32'hFFFF_FFF8, 8'd1, 13'd3);
    ready = 1'b1;
    push(32'hFFFF_FFF8, 0); push(32'hFFFF_FFFC, 0); push(32'h0, 0); push(32'h4, 1);
    do_start();
    cyc(3);
    check("wrap_addr0", address, 32'h4);
    cyc(1);
    check("wrap_done", {31'd0, done}, 32'd1);
    cfg(MODE_SINGLE, 32'h10, 8'd1, 13'd0);
    push(32'h10, 1);
    do_start();
    check("start_in_done_valid", {31'd0, valid}, 32'd1);
    check("start_in_done_addr", address, 32'h10);
    cyc(1);
    check("start_in_done_pulse", {31'd0, done}, 32'd1);
    cyc(2);
    check("final_queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
